wdf_alloc: RTL and testbench

// - Write-buffer slot allocator upstream of the write data FIFO. Accepts write commands (addr+64b data) from TL receive,

---
 rtl/wdf_alloc.sv | 150 +++++++++++++++
 tb/tb_wdf_alloc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wdf_alloc.sv
// Write-buffer slot allocator: grants the lowest free slot to each write command, feeds the write data FIFO and SRQ,
// and recycles slots on SRQ release. Optional statistics counters are enabled by defining WDF_ALLOC_STATS_EN.
module wdf_alloc #(
  parameter int PTR_W  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tlx_wr_valid,
  output logic              tlx_wr_ready,
  input  logic [ADDR_W-1:0] tlx_wr_addr,
  input  logic [DATA_W-1:0] tlx_wr_data,
  output logic              tlxr_wdf_wr,
  output logic              tlxr_wdf_wr_p,
  output logic [PTR_W-1:0]  tlxr_wdf_ptr,
  output logic [DATA_W-1:0] tlxr_wdf_data,
  output logic              srq_cmd_valid,
  input  logic              srq_cmd_ready,
  output logic [ADDR_W-1:0] srq_cmd_addr,
  output logic [PTR_W-1:0]  srq_cmd_ptr,
  input  logic              srq_wdf_rd,
  input  logic [PTR_W-1:0]  srq_wdf_ptr,
  input  logic              srq_wdf_p,
  output logic [PTR_W:0]    free_cnt,
  output logic [1:0]        fir
`ifdef WDF_ALLOC_STATS_EN
  ,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_stall_cnt
`endif
);

  localparam int NSLOT = 1 << PTR_W;

  typedef enum logic [1:0] {IDLE, GAP, CMD} state_e;

  state_e              state_q, state_d;
  logic [NSLOT-1:0]    free_q, free_d;
  logic                wr_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                cmd_vld_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [PTR_W-1:0]    cmd_ptr_q;
  logic [1:0]          fir_q;
  logic [PTR_W:0]      cnt;
  logic [PTR_W-1:0]    slot;
  logic                accept;
  logic                rel_par_err;
  logic                rel_dup;
  logic                rel_ok;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NSLOT; i++) begin
      cnt = cnt + {{PTR_W{1'b0}}, free_q[i]};
    end
  end

  // Descending scan so the lowest free index wins.
  always_comb begin
    slot = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (free_q[i]) slot = PTR_W'(i);
    end
  end

  assign tlx_wr_ready = (state_q == IDLE) && (cnt != '0) && !cmd_vld_q;
  assign accept       = tlx_wr_valid && tlx_wr_ready;

  assign rel_par_err = srq_wdf_rd && (^{srq_wdf_rd, srq_wdf_p, srq_wdf_ptr});
  assign rel_dup     = srq_wdf_rd && !rel_par_err && free_q[srq_wdf_ptr];
  assign rel_ok      = srq_wdf_rd && !rel_par_err && !free_q[srq_wdf_ptr];

  // A released slot is still busy in free_q, so it can never collide with this cycle's grant.
  always_comb begin
    free_d = free_q;
    if (accept) free_d[slot] = 1'b0;
    if (rel_ok) free_d[srq_wdf_ptr] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = GAP;
      GAP:     state_d = (cmd_vld_q && !srq_cmd_ready) ? CMD : IDLE;
      CMD:     if (srq_cmd_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      free_q     <= '1;
      wr_q       <= 1'b0;
      wr_ptr_q   <= '0;
      wr_data_q  <= '0;
      cmd_vld_q  <= 1'b0;
      cmd_addr_q <= '0;
      cmd_ptr_q  <= '0;
      fir_q      <= '0;
    end else begin
      state_q <= state_d;
      free_q  <= free_d;
      wr_q    <= accept;
      // Pointer returns to zero between strobes so the idle bus carries even parity with p=0.
      wr_ptr_q <= accept ? slot : '0;
      if (accept) begin
        wr_data_q  <= tlx_wr_data;
        cmd_addr_q <= tlx_wr_addr;
        cmd_ptr_q  <= slot;
      end
      if (accept) cmd_vld_q <= 1'b1;
      else if (srq_cmd_ready) cmd_vld_q <= 1'b0;
      fir_q <= fir_q | {rel_dup, rel_par_err};
    end
  end

  assign tlxr_wdf_wr   = wr_q;
  assign tlxr_wdf_wr_p = ^{wr_q, wr_ptr_q};
  assign tlxr_wdf_ptr  = wr_ptr_q;
  assign tlxr_wdf_data = wr_data_q;
  assign srq_cmd_valid = cmd_vld_q;
  assign srq_cmd_addr  = cmd_addr_q;
  assign srq_cmd_ptr   = cmd_ptr_q;
  assign free_cnt      = cnt;
  assign fir           = fir_q;

`ifdef WDF_ALLOC_STATS_EN
  logic [15:0] stat_wr_q;
  logic [15:0] stat_stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (accept && (stat_wr_q != 16'hFFFF)) stat_wr_q <= stat_wr_q + 16'd1;
      if (tlx_wr_valid && !tlx_wr_ready && (cnt == '0) && (stat_stall_q != 16'hFFFF))
        stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_wr_cnt    = stat_wr_q;
  assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_wdf_alloc.sv
// Directed bench for wdf_alloc: table of per-cycle vectors plus hand sequences for reset and single write.
module tb_wdf_alloc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tlx_wr_valid;
  logic        tlx_wr_ready;
  logic [31:0] tlx_wr_addr;
  logic [63:0] tlx_wr_data;
  logic        tlxr_wdf_wr;
  logic        tlxr_wdf_wr_p;
  logic [2:0]  tlxr_wdf_ptr;
  logic [63:0] tlxr_wdf_data;
  logic        srq_cmd_valid;
  logic        srq_cmd_ready;
  logic [31:0] srq_cmd_addr;
  logic [2:0]  srq_cmd_ptr;
  logic        srq_wdf_rd;
  logic [2:0]  srq_wdf_ptr;
  logic        srq_wdf_p;
  logic [3:0]  free_cnt;
  logic [1:0]  fir;
`ifdef WDF_ALLOC_STATS_EN
  logic [15:0] stat_wr_cnt;
  logic [15:0] stat_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wdf_alloc dut (
    .clk           (clk),
    .rstn          (rstn),
    .tlx_wr_valid  (tlx_wr_valid),
    .tlx_wr_ready  (tlx_wr_ready),
    .tlx_wr_addr   (tlx_wr_addr),
    .tlx_wr_data   (tlx_wr_data),
    .tlxr_wdf_wr   (tlxr_wdf_wr),
    .tlxr_wdf_wr_p (tlxr_wdf_wr_p),
    .tlxr_wdf_ptr  (tlxr_wdf_ptr),
    .tlxr_wdf_data (tlxr_wdf_data),
    .srq_cmd_valid (srq_cmd_valid),
    .srq_cmd_ready (srq_cmd_ready),
    .srq_cmd_addr  (srq_cmd_addr),
    .srq_cmd_ptr   (srq_cmd_ptr),
    .srq_wdf_rd    (srq_wdf_rd),
    .srq_wdf_ptr   (srq_wdf_ptr),
    .srq_wdf_p     (srq_wdf_p),
    .free_cnt      (free_cnt),
    .fir           (fir)
`ifdef WDF_ALLOC_STATS_EN
    ,
    .stat_wr_cnt   (stat_wr_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic        crdy;
    logic        rd;
    logic [2:0]  rptr;
    logic        rp;
    logic        ewr;
    logic [2:0]  eptr;
    logic        ecv;
    logic [31:0] ecaddr;
    logic [2:0]  ecptr;
    logic [3:0]  ecnt;
    logic        erdy;
    logic [1:0]  efir;
  } vec_t;

  vec_t tbl[36];

  function automatic vec_t v(input logic vld, input logic [31:0] addr, input logic crdy,
                             input logic rd, input logic [2:0] rptr, input logic rp,
                             input logic ewr, input logic [2:0] eptr, input logic ecv,
                             input logic [31:0] ecaddr, input logic [2:0] ecptr,
                             input logic [3:0] ecnt, input logic erdy, input logic [1:0] efir);
    vec_t r;
    r.vld = vld; r.addr = addr; r.crdy = crdy; r.rd = rd; r.rptr = rptr; r.rp = rp;
    r.ewr = ewr; r.eptr = eptr; r.ecv = ecv; r.ecaddr = ecaddr; r.ecptr = ecptr;
    r.ecnt = ecnt; r.erdy = erdy; r.efir = efir;
    return r;
  endfunction

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {32'hDA7A_0000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_wr;

    // burst with valid held high and SRQ always ready: grant every 2nd cycle, slots 0..7
    tbl[0]  = v(1, 32'h2001, 1, 0, 0, 0, 1, 0, 1, 32'h2001, 0, 7, 0, 0);
    tbl[1]  = v(1, 32'h2002, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0);
    tbl[2]  = v(1, 32'h2003, 1, 0, 0, 0, 1, 1, 1, 32'h2003, 1, 6, 0, 0);
    tbl[3]  = v(1, 32'h2004, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0);
    tbl[4]  = v(1, 32'h2005, 1, 0, 0, 0, 1, 2, 1, 32'h2005, 2, 5, 0, 0);
    tbl[5]  = v(1, 32'h2006, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0);
    tbl[6]  = v(1, 32'h2007, 1, 0, 0, 0, 1, 3, 1, 32'h2007, 3, 4, 0, 0);
    tbl[7]  = v(1, 32'h2008, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0);
    tbl[8]  = v(1, 32'h2009, 1, 0, 0, 0, 1, 4, 1, 32'h2009, 4, 3, 0, 0);
    tbl[9]  = v(1, 32'h200A, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    tbl[10] = v(1, 32'h200B, 1, 0, 0, 0, 1, 5, 1, 32'h200B, 5, 2, 0, 0);
    tbl[11] = v(1, 32'h200C, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
    tbl[12] = v(1, 32'h200D, 1, 0, 0, 0, 1, 6, 1, 32'h200D, 6, 1, 0, 0);
    tbl[13] = v(1, 32'h200E, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[14] = v(1, 32'h200F, 1, 0, 0, 0, 1, 7, 1, 32'h200F, 7, 0, 0, 0);
    tbl[15] = v(1, 32'h2010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // full: stall, then release slot 5 and regrant it
    tbl[16] = v(1, 32'h3000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = v(1, 32'h3001, 1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[18] = v(1, 32'h3005, 1, 0, 0, 0, 1, 5, 1, 32'h3005, 5, 0, 0, 0);
    tbl[19] = v(0, 32'h3006, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // bad parity on slot 3, then double release of slot 6
    tbl[20] = v(0, 32'h3007, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[21] = v(0, 32'h0,    1, 1, 6, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[22] = v(0, 32'h0,    1, 1, 6, 1, 0, 0, 0, 0, 0, 1, 1, 3);
    tbl[23] = v(0, 32'h0,    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    tbl[24] = v(0, 32'h0,    1, 1, 3, 1, 0, 0, 0, 0, 0, 2, 1, 3);
    // SRQ back-pressure for 4 cycles
    tbl[25] = v(1, 32'h4000, 0, 0, 0, 0, 1, 3, 1, 32'h4000, 3, 1, 0, 3);
    tbl[26] = v(1, 32'h4001, 0, 0, 0, 0, 0, 0, 1, 32'h4000, 3, 1, 0, 3);
    tbl[27] = v(1, 32'h4002, 0, 0, 0, 0, 0, 0, 1, 32'h4000, 3, 1, 0, 3);
    tbl[28] = v(1, 32'h4003, 0, 0, 0, 0, 0, 0, 1, 32'h4000, 3, 1, 0, 3);
    tbl[29] = v(1, 32'h4004, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    tbl[30] = v(1, 32'h4005, 1, 0, 0, 0, 1, 6, 1, 32'h4005, 6, 0, 0, 3);
    // same-cycle grant of slot 0 and release of slot 2
    tbl[31] = v(0, 32'h0,    1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3);
    tbl[32] = v(1, 32'h5000, 1, 1, 2, 0, 1, 0, 1, 32'h5000, 0, 1, 0, 3);
    tbl[33] = v(0, 32'h0,    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    tbl[34] = v(1, 32'h5001, 1, 0, 0, 0, 1, 2, 1, 32'h5001, 2, 0, 0, 3);
    tbl[35] = v(0, 32'h0,    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);

    rstn = 1'b0;
    tlx_wr_valid = 1'b0; tlx_wr_addr = '0; tlx_wr_data = '0;
    srq_cmd_ready = 1'b0; srq_wdf_rd = 1'b0; srq_wdf_ptr = '0; srq_wdf_p = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    chk("rst free_cnt", free_cnt, 8);
    chk("rst wdf_wr", tlxr_wdf_wr, 0);
    chk("rst wdf_p", tlxr_wdf_wr_p, 0);
    chk("rst wdf_data", tlxr_wdf_data, 0);
    chk("rst cmd_valid", srq_cmd_valid, 0);
    chk("rst cmd_addr", srq_cmd_addr, 0);
    chk("rst fir", fir, 0);
    step();
    chk("idle ready", tlx_wr_ready, 1);

    // single write
    tlx_wr_valid = 1'b1; tlx_wr_addr = 32'h100; tlx_wr_data = 64'hDEAD; srq_cmd_ready = 1'b1;
    step();
    tlx_wr_valid = 1'b0;
    chk("w1 wdf_wr", tlxr_wdf_wr, 1);
    chk("w1 wdf_ptr", tlxr_wdf_ptr, 0);
    chk("w1 wdf_p", tlxr_wdf_wr_p, 1);
    chk("w1 wdf_data", tlxr_wdf_data, 64'hDEAD);
    chk("w1 cmd_valid", srq_cmd_valid, 1);
    chk("w1 cmd_addr", srq_cmd_addr, 32'h100);
    chk("w1 cmd_ptr", srq_cmd_ptr, 0);
    chk("w1 free_cnt", free_cnt, 7);
    step();
    chk("w1 wr pulse", tlxr_wdf_wr, 0);
    chk("w1 idle p", tlxr_wdf_wr_p, 0);
    chk("w1 cmd drop", srq_cmd_valid, 0);
    srq_wdf_rd = 1'b1; srq_wdf_ptr = 3'd0; srq_wdf_p = 1'b1;
    step();
    srq_wdf_rd = 1'b0;
    chk("w1 rel free_cnt", free_cnt, 8);
    chk("w1 rel fir", fir, 0);

    prev_wr = 1'b0;
    for (int i = 0; i < 36; i++) begin
      tlx_wr_valid  = tbl[i].vld;
      tlx_wr_addr   = tbl[i].addr;
      tlx_wr_data   = data_of(tbl[i].addr);
      srq_cmd_ready = tbl[i].crdy;
      srq_wdf_rd    = tbl[i].rd;
      srq_wdf_ptr   = tbl[i].rptr;
      srq_wdf_p     = tbl[i].rp;
      step();
      chk($sformatf("row%0d wdf_wr", i), tlxr_wdf_wr, tbl[i].ewr);
      chk($sformatf("row%0d cmd_valid", i), srq_cmd_valid, tbl[i].ecv);
      chk($sformatf("row%0d free_cnt", i), free_cnt, tbl[i].ecnt);
      chk($sformatf("row%0d ready", i), tlx_wr_ready, tbl[i].erdy);
      chk($sformatf("row%0d fir", i), fir, tbl[i].efir);
      chk($sformatf("row%0d parity", i), ^{tlxr_wdf_wr, tlxr_wdf_wr_p, tlxr_wdf_ptr}, 0);
      chk($sformatf("row%0d back2back", i), prev_wr & tlxr_wdf_wr, 0);
      if (tbl[i].ewr) begin
        chk($sformatf("row%0d wdf_ptr", i), tlxr_wdf_ptr, tbl[i].eptr);
        chk($sformatf("row%0d wdf_data", i), tlxr_wdf_data, data_of(tbl[i].addr));
      end else begin
        chk($sformatf("row%0d idle p", i), tlxr_wdf_wr_p, 0);
      end
      if (tbl[i].ecv) begin
        chk($sformatf("row%0d cmd_addr", i), srq_cmd_addr, tbl[i].ecaddr);
        chk($sformatf("row%0d cmd_ptr", i), srq_cmd_ptr, tbl[i].ecptr);
      end
      prev_wr = tlxr_wdf_wr;
    end
    srq_wdf_rd = 1'b0;
    tlx_wr_valid = 1'b0;

    // reset asserted mid-burst, right after a grant
    srq_wdf_rd = 1'b1; srq_wdf_ptr = 3'd1; srq_wdf_p = 1'b0;
    step();
    srq_wdf_rd = 1'b0;
    chk("mid rel free_cnt", free_cnt, 1);
    tlx_wr_valid = 1'b1; tlx_wr_addr = 32'h5500; tlx_wr_data = data_of(32'h5500);
    step();
    chk("mid grant ptr", tlxr_wdf_ptr, 1);
    rstn = 1'b0;
    #1;
    chk("mid rst free_cnt", free_cnt, 8);
    chk("mid rst wdf_wr", tlxr_wdf_wr, 0);
    chk("mid rst cmd_valid", srq_cmd_valid, 0);
    chk("mid rst fir", fir, 0);
    tlx_wr_valid = 1'b0;
    step();
    step();
    rstn = 1'b1;
    tlx_wr_valid = 1'b1; tlx_wr_addr = 32'h6000; tlx_wr_data = data_of(32'h6000);
    step();
    tlx_wr_valid = 1'b0;
    chk("post rst wdf_wr", tlxr_wdf_wr, 1);
    chk("post rst ptr", tlxr_wdf_ptr, 0);
    chk("post rst cmd_addr", srq_cmd_addr, 32'h6000);
    chk("post rst free_cnt", free_cnt, 7);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
